// File: rtl/reset_sequencer.sv
// Staged reset release with per-stage ready handshake, timeout fault and RUN tick.
// Optional stage-drop monitor in RUN: define RST_SEQ_MONITOR_EN.
module reset_sequencer #(
  parameter int unsigned STRETCH    = 16,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned STAGE_GAP  = 4,
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned TICK_DIV   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  all_ready,
  output logic                  tick,
  output logic                  fault,
  output logic [2:0]            state_o
);

  localparam int unsigned MAX_A   = (STRETCH > TIMEOUT) ? STRETCH : TIMEOUT;
  localparam int unsigned MAX_B   = (STAGE_GAP > TICK_DIV) ? STAGE_GAP : TICK_DIV;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_STRETCH = 3'd1,
    S_WAIT    = 3'd2,
    S_GAP     = 3'd3,
    S_RUN     = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t                r_state, w_state;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [IDX_W-1:0]      r_idx, w_idx, w_idx_inc;
  logic [NUM_STAGES-1:0] r_rst_n, w_rst_n;
  logic                  r_all_ready, w_all_ready;
  logic                  r_tick, w_tick;
  logic                  r_fault, w_fault;

  assign w_idx_inc = r_idx + IDX_W'(1);

  // State and all output registers; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_n     <= '0;
      r_all_ready <= 1'b0;
      r_tick      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_rst_n     <= w_rst_n;
      r_all_ready <= w_all_ready;
      r_tick      <= w_tick;
      r_fault     <= w_fault;
    end
  end

  // Next-state and next-output logic; the shared counter restarts on every state entry.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt + CNT_W'(1);
    w_idx       = r_idx;
    w_rst_n     = r_rst_n;
    w_all_ready = r_all_ready;
    w_tick      = 1'b0;
    w_fault     = r_fault;

    case (r_state)
      S_HOLD: begin
        w_state     = S_STRETCH;
        w_cnt       = '0;
        w_idx       = '0;
        w_rst_n     = '0;
        w_all_ready = 1'b0;
        w_fault     = 1'b0;
      end

      S_STRETCH: begin
        if (r_cnt == CNT_W'(STRETCH - 1)) begin
          w_state    = S_WAIT;
          w_cnt      = '0;
          w_idx      = '0;
          w_rst_n[0] = 1'b1;
        end
      end

      S_WAIT: begin
        if (stage_ready[r_idx]) begin
          w_state = S_GAP;
          w_cnt   = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state     = S_FAULT;
          w_cnt       = '0;
          w_rst_n     = '0;
          w_all_ready = 1'b0;
          w_fault     = 1'b1;
        end
      end

      S_GAP: begin
        if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
          w_cnt = '0;
          if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
            w_state     = S_RUN;
            w_all_ready = 1'b1;
          end else begin
            w_state            = S_WAIT;
            w_idx              = w_idx_inc;
            w_rst_n[w_idx_inc] = 1'b1;
          end
        end
      end

      S_RUN: begin
`ifdef RST_SEQ_MONITOR_EN
        if (stage_ready != {NUM_STAGES{1'b1}}) begin
          w_state     = S_FAULT;
          w_cnt       = '0;
          w_rst_n     = '0;
          w_all_ready = 1'b0;
          w_fault     = 1'b1;
        end else
`endif
        if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
          w_cnt  = '0;
          w_tick = 1'b1;
        end
      end

      S_FAULT: begin
        w_cnt       = r_cnt;
        w_rst_n     = '0;
        w_all_ready = 1'b0;
        w_fault     = 1'b1;
      end

      default: begin
        w_state = S_HOLD;
        w_cnt   = '0;
      end
    endcase
  end

  assign rst_out_n = r_rst_n;
  assign all_ready = r_all_ready;
  assign tick      = r_tick;
  assign fault     = r_fault;
  assign state_o   = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes per-edge expectations, a negedge monitor checks them.
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] stage_ready;
  logic [2:0] rst_out_n;
  logic       all_ready;
  logic       tick;
  logic       fault;
  logic [2:0] state_o;
  logic [2:0] mask;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] rst;
    logic       ar;
    logic       tk;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  int   tag_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  reset_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stage_ready(stage_ready),
    .rst_out_n  (rst_out_n),
    .all_ready  (all_ready),
    .tick       (tick),
    .fault      (fault),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream stages report ready as soon as they are released, unless masked off.
  assign stage_ready = rst_out_n & mask;

  // Hand-derived timeline for a clean release; n = edges since reset went high.
  function automatic exp_t nominal(input int n);
    exp_t e;
    e = '{st: 3'd1, rst: 3'b000, ar: 1'b0, tk: 1'b0, flt: 1'b0};
    if (n == 17)                 e = '{3'd2, 3'b001, 1'b0, 1'b0, 1'b0};
    else if (n >= 18 && n <= 21) e = '{3'd3, 3'b001, 1'b0, 1'b0, 1'b0};
    else if (n == 22)            e = '{3'd2, 3'b011, 1'b0, 1'b0, 1'b0};
    else if (n >= 23 && n <= 26) e = '{3'd3, 3'b011, 1'b0, 1'b0, 1'b0};
    else if (n == 27)            e = '{3'd2, 3'b111, 1'b0, 1'b0, 1'b0};
    else if (n >= 28 && n <= 31) e = '{3'd3, 3'b111, 1'b0, 1'b0, 1'b0};
    else if (n >= 32)
      e = '{3'd4, 3'b111, 1'b1, ((n >= 42) && ((n - 42) % 10 == 0)), 1'b0};
    return e;
  endfunction

  localparam exp_t E_HOLD  = '{3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_FAULT = '{3'd5, 3'b000, 1'b0, 1'b0, 1'b1};

  // Wait for the next active edge, then queue what the outputs must show after it.
  task automatic edge_exp(input exp_t e, input int tag);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare registered outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    int   t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '{state_o, rst_out_n, all_ready, tick, fault};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outputs tag=%0d got st=%0d rst=%b ar=%b tk=%b flt=%b want st=%0d rst=%b ar=%b tk=%b flt=%b",
                 t, a.st, a.rst, a.ar, a.tk, a.flt, e.st, e.rst, e.ar, e.tk, e.flt);
      end
    end
  end

  initial begin
    reset = 1'b0;
    mask  = 3'b111;

    // Scenario 1/2: reset for 3 edges, then full sequence and RUN ticks at 42, 52, 62.
    repeat (3) edge_exp(E_HOLD, 1000);
    reset = 1'b1;
    for (int n = 1; n <= 65; n++) edge_exp(nominal(n), 1000 + n);

    // Scenario 4: reset mid-sequence at relative edge 25, then a replay.
    reset = 1'b0;
    edge_exp(E_HOLD, 4000);
    reset = 1'b1;
    for (int n = 1; n <= 24; n++) edge_exp(nominal(n), 4000 + n);
    reset = 1'b0;
    edge_exp(E_HOLD, 4025);
    reset = 1'b1;
    for (int n = 1; n <= 35; n++) edge_exp(nominal(n), 4100 + n);

    // Scenario 3: stage 1 never reports ready -> timeout FAULT at edge 54, then sticky.
    reset = 1'b0;
    edge_exp(E_HOLD, 3000);
    reset = 1'b1;
    mask  = 3'b101;
    for (int n = 1; n <= 21; n++) edge_exp(nominal(n), 3000 + n);
    for (int n = 22; n <= 53; n++) edge_exp('{3'd2, 3'b011, 1'b0, 1'b0, 1'b0}, 3000 + n);
    edge_exp(E_FAULT, 3054);
    for (int n = 1; n <= 100; n++) edge_exp(E_FAULT, 3100 + n);

    // Scenario 5: one-cycle reset pulse clears the fault; clean sequence follows.
    reset = 1'b0;
    edge_exp(E_HOLD, 5000);
    reset = 1'b1;
    mask  = 3'b111;
    for (int n = 1; n <= 44; n++) edge_exp(nominal(n), 5000 + n);

    // Scenario 6/7: drop stage_ready[2] for the single edge 45 while in RUN.
    mask = 3'b011;
    edge_exp(
`ifdef RST_SEQ_MONITOR_EN
      E_FAULT,
`else
      nominal(45),
`endif
      5045);
    mask = 3'b111;
    for (int n = 46; n <= 70; n++)
      edge_exp(
`ifdef RST_SEQ_MONITOR_EN
        E_FAULT,
`else
        nominal(n),
`endif
        5000 + n);

    // Let the monitor drain the remaining expectation.
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the raw bench/board clock `clk` and the raw reset `reset`.
- Produces staged, stretched per-stage resets for downstream blocks, with a ready handshake per stage.
- Generates a periodic clock-enable tick once all stages run.
- Sits directly downstream of the clock/reset source, upstream of every functional block.

Parameters:
- STRETCH, 16: cycles reset stays held after the raw `reset` deasserts; must be ≥1.
- NUM_STAGES, 3: number of staged reset outputs; range 1..8.
- STAGE_GAP, 4: cycles between a stage's ready and the next stage's release; must be ≥1.
- TIMEOUT, 32: maximum cycles to wait for a stage's ready; must be ≥1.
- TICK_DIV, 10: tick period in cycles while running; must be ≥2.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset (0 = reset asserted).
- stage_ready, input, NUM_STAGES: bit k is high when stage k has come out of reset.
- rst_out_n, output, NUM_STAGES: per-stage reset, active-low.
- all_ready, output, 1: high while in RUN.
- tick, output, 1: one-cycle clock-enable pulse in RUN.
- fault, output, 1: sticky fault flag.
- state_o, output, 3: current FSM state, for debug.

Behaviour:
- All outputs are registered.
- While `reset` is 0 at an edge:
  - state=HOLD, and all counters and the stage index are cleared.
  - rst_out_n=0, all_ready=0, tick=0, fault=0.
  - This applies from any state (reset mid-operation aborts the sequence).
- State encoding for state_o: HOLD=0, STRETCH=1, WAIT=2, GAP=3, RUN=4, FAULT=5.
- One shared counter `cnt` is cleared on every state entry.
- HOLD: at the first edge with reset=1, go to STRETCH.
- STRETCH:
  - At an edge with cnt==STRETCH-1, go to WAIT with idx=0 and set rst_out_n[0]=1.
  - Otherwise cnt++.
- WAIT:
  - stage_ready[idx]=1 at an edge: go to GAP.
  - Else cnt==TIMEOUT-1: go to FAULT.
  - Else cnt++.
- GAP:
  - At an edge with cnt==STAGE_GAP-1:
    - If idx==NUM_STAGES-1: go to RUN, all_ready=1.
    - Else: idx++, set rst_out_n[idx+1]=1, go to WAIT.
  - Otherwise cnt++.
- Released stages stay released (rst_out_n bits only rise) until HOLD or FAULT.
- RUN:
  - A divider counts 0..TICK_DIV-1 and wraps.
  - tick is high for exactly the one cycle following each edge at which the divider wraps.
  - The first tick follows the TICK_DIV-th edge after entering RUN; ticks are then periodic with period TICK_DIV.
- FAULT:
  - fault=1, rst_out_n=all 0, all_ready=0, tick=0.
  - Sticky; exits only via reset=0.
- Bits of stage_ready for stages not yet released are ignored.
- In WAIT, a ready already high on the first WAIT edge is accepted: a one-cycle WAIT is legal.

Optional Feature:
- Macro: RST_SEQ_MONITOR_EN.
- Defined: in RUN, any edge with a stage_ready bit at 0 sends the FSM to FAULT on that edge (stage-drop monitor).
- Undefined: stage_ready is ignored in RUN; the FAULT state is reachable only via timeout.

Test Plan (defaults; edge 1 = first edge with reset=1; bench drives stage_ready = rst_out_n):
- reset=0 for 3 edges, then 1 →
  - rst_out_n[0] rises after edge 17; GAP entered at edge 18.
  - rst_out_n[1] rises after edge 22; rst_out_n[2] after edge 27.
  - all_ready=1 after edge 32; state_o sequence 0,1,2,3,2,3,2,3,4.
- Same as above, continuing in RUN → tick pulses after edges 42, 52, 62; each pulse lasts exactly 1 cycle; no other tick.
- stage_ready[1] held at 0 → WAIT for idx 1 entered at edge 22; FAULT at edge 54 (22+32); fault=1, rst_out_n=000; holds 100 cycles.
- reset driven 0 at edge 25 (mid-sequence), then 1 →
  - Next edge: state 0, rst_out_n=000, fault=0.
  - Full sequence replays with identical timing relative to the new release.
- From the FAULT of scenario 3, pulse reset=0 for 1 cycle → fault clears; with correct ready, all_ready=1 at relative edge 32.
- RST_SEQ_MONITOR_EN defined: in RUN, drop stage_ready[2] for 1 cycle → FAULT on that edge, tick stops.
- RST_SEQ_MONITOR_EN undefined: same stimulus → stays in RUN, ticks continue.
